// File: rtl/vector_lsu_pkg.sv
// vector_lsu_pkg: core phase and LSU state encodings shared by the register file, scheduler and LSU
package vector_lsu_pkg;

    typedef enum logic [2:0] {
        CORE_REQUEST = 3'b011,
        CORE_UPDATE  = 3'b110
    } core_state_e;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/vector_lsu.sv
// vector_lsu: per-thread load/store unit issuing one memory transaction per lane
//   clk, reset (async, active-high), enable (thread active; low freezes everything)
//   core_state          : core phase, trigger in REQUEST, release in UPDATE
//   decoded_mem_*_enable: LDR / STR, read wins when both are set
//   decoded_vector_mux  : 1 = Vector_Size lanes, 0 = single scalar lane
//   rs / rt / v_rt      : base address, scalar store data, vector store data
//   mem_read_*          : valid/address out, ready/data in
//   mem_write_*         : valid/address/data out, ready in
//   lsu_state           : IDLE/REQUESTING/WAITING/DONE
//   lsu_out / v_lsu_out : last scalar / vector load result
module vector_lsu
    import vector_lsu_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int ADDR_BITS   = 8,
    parameter int Vector_Size = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [2:0]                       core_state,
    input  logic                             decoded_mem_read_enable,
    input  logic                             decoded_mem_write_enable,
    input  logic                             decoded_vector_mux,
    input  logic [7:0]                       rs,
    input  logic [7:0]                       rt,
    input  logic [Vector_Size*DATA_BITS-1:0] v_rt,
    output logic                             mem_read_valid,
    output logic [ADDR_BITS-1:0]             mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [DATA_BITS-1:0]             mem_read_data,
    output logic                             mem_write_valid,
    output logic [ADDR_BITS-1:0]             mem_write_address,
    output logic [DATA_BITS-1:0]             mem_write_data,
    input  logic                             mem_write_ready,
    output logic [1:0]                       lsu_state,
    output logic [DATA_BITS-1:0]             lsu_out,
    output logic [Vector_Size*DATA_BITS-1:0] v_lsu_out
);

    localparam int LW = $clog2(Vector_Size + 1);

    lsu_state_e           r_state;
    lsu_state_e           w_next;
    logic                 r_is_read;
    logic                 r_is_vec;
    logic [LW-1:0]        r_lanes;
    logic [LW-1:0]        r_lane;
    logic                 w_trigger;
    logic                 w_ready;
    logic                 w_last;
    logic [ADDR_BITS-1:0] w_addr;
    logic [DATA_BITS-1:0] w_wdata;

    assign w_trigger = (core_state == CORE_REQUEST) && (decoded_mem_read_enable || decoded_mem_write_enable);
    assign w_ready   = r_is_read ? mem_read_ready : mem_write_ready;
    assign w_last    = r_lane == r_lanes - LW'(1);
    assign w_addr    = ADDR_BITS'(rs) + ADDR_BITS'(r_lane);
    assign w_wdata   = r_is_vec ? v_rt[int'(r_lane)*DATA_BITS +: DATA_BITS] : DATA_BITS'(rt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= LSU_IDLE;
        else if (enable)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LSU_IDLE:       w_next = w_trigger ? LSU_REQUESTING : LSU_IDLE;
            LSU_REQUESTING: w_next = LSU_WAITING;
            LSU_WAITING:    w_next = !w_ready ? LSU_WAITING : (w_last ? LSU_DONE : LSU_REQUESTING);
            LSU_DONE:       w_next = (core_state == CORE_UPDATE) ? LSU_IDLE : LSU_DONE;
            default:        w_next = LSU_IDLE;
        endcase
    end

    always_comb lsu_state = r_state;

    // Transaction and result registers; ready is only honoured in WAITING.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_read         <= 1'b0;
            r_is_vec          <= 1'b0;
            r_lanes           <= '0;
            r_lane            <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
            v_lsu_out         <= '0;
        end else if (enable) begin
            if (r_state == LSU_IDLE && w_trigger) begin
                r_is_read <= decoded_mem_read_enable;
                r_is_vec  <= decoded_vector_mux;
                r_lanes   <= decoded_vector_mux ? LW'(Vector_Size) : LW'(1);
                r_lane    <= '0;
            end
            if (r_state == LSU_REQUESTING) begin
                if (r_is_read) begin
                    mem_read_valid   <= 1'b1;
                    mem_read_address <= w_addr;
                end else begin
                    mem_write_valid   <= 1'b1;
                    mem_write_address <= w_addr;
                    mem_write_data    <= w_wdata;
                end
            end
            if (r_state == LSU_WAITING && w_ready) begin
                mem_read_valid  <= 1'b0;
                mem_write_valid <= 1'b0;
                if (r_is_read && r_is_vec)
                    v_lsu_out[int'(r_lane)*DATA_BITS +: DATA_BITS] <= mem_read_data;
                if (r_is_read && !r_is_vec)
                    lsu_out <= mem_read_data;
                if (!w_last)
                    r_lane <= r_lane + LW'(1);
            end
        end
    end

endmodule
